zifi_uart_rx: RTL and testbench
===============================

// Module: zifi_uart_rx
// PURPOSE
//  8N1 serial receiver for the ZiFi UART path: the line-side end that turns uart_rx
//  into bytes and hands them to the register front-end (rxdata/rxrecv/data_read).
//  Oversampled bit recovery, show-ahead receive FIFO, RTS flow control with hysteresis.
// PARAMETERS
//  CLK_HZ      28000000  clk_bus frequency, Hz
//  BAUD        115200    line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit
//  FIFO_AW     4         FIFO address width; depth = 2**FIFO_AW
//  RTS_HI      12        count >= RTS_HI raises rts (stop sender)
//  RTS_LO      4         count <= RTS_LO drops rts (resume); RTS_LO < RTS_HI
// PORTS
//  clk_bus    in   1  system clock; every register on its rising edge
//  rst        in   1  synchronous reset, active-high
//  uart_rx    in   1  asynchronous serial input, idle high
//  data_read  in   1  level; high while the CPU reads the data register, may last N cycles
//  rxdata     out  8  FIFO head byte (show-ahead); valid while rxrecv=1
//  rxrecv     out  1  FIFO not empty
//  rts        out  1  1 = stop sending, 0 = ready
//  ovr        out  1  sticky: byte dropped because FIFO was full
//  ferr       out  1  sticky framing error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, rxrecv=0, rxdata=8'h00, rts=0, ovr=0, ferr=0,
//   synchronizer flops preset to 1. Reset asserted mid-frame aborts the frame; nothing pushed.
//  Input: 2-flop synchronizer on uart_rx; all decisions use the synced bit rxs.
//  FSM states IDLE, START, DATA, STOP; bit timer counts 0..DIV-1.
//   IDLE : rxs=0 -> START, timer=0.
//   START: at timer=DIV/2-1 sample; rxs=1 -> IDLE (glitch, no push), else -> DATA, timer=0.
//   DATA : sample at timer=DIV-1 (bit centre); shift in LSB first; after 8th bit -> STOP.
//   STOP : sample at bit centre; push result this cycle; -> IDLE same cycle, so a start
//          edge is seen at most 1 bit-half later (back-to-back frames supported).
//  FIFO: 2**FIFO_AW x 8, wrap-around pointers, count width FIFO_AW+1.
//   push when count<depth; push when full -> byte dropped, ovr<=1.
//   pop on rising edge of data_read (data_read & ~data_read_q) when count>0; one pop per
//   high level regardless of duration; pop on empty ignored.
//   push+pop same cycle: both performed, count unchanged; holds when full (push accepted).
//   rxdata/rxrecv reflect new head the cycle after push/pop (registered).
//  ovr and ferr clear on a valid pop or reset only.
//  rts: set when count>=RTS_HI, cleared when count<=RTS_LO, else holds; updated the cycle
//   after count changes. Receiver keeps accepting bytes while rts=1.
// CONFIGURATION
//  Macro ZIFI_UART_RX_FRAME_CHECK_EN:
//   defined  : stop sample 0 -> byte discarded (not pushed), ferr<=1; FSM -> IDLE; if rxs is
//              still 0 it is treated as a new start bit only after rxs returns to 1.
//   undefined: stop bit not checked, byte always pushed, ferr tied 0.
// TESTING  (CLK_HZ=28000000, BAUD=115200 -> DIV=243, FIFO_AW=4, RTS_HI=12, RTS_LO=4)
//  1 Frame 0xA5 8N1 -> rxrecv rises 2310+/-3 clk after start edge; rxdata=8'hA5; rts=0.
//  2 uart_rx low for 50 clk then high -> no push, rxrecv stays 0, FSM back in IDLE.
//  3 17 frames 0x00..0x10 back-to-back, no reads -> rts=1 after 12th byte, 0x10 dropped,
//    ovr=1; 16 reads return 0x00..0x0F; rts=0 once count reaches 4; ovr=0 after first pop.
//  4 data_read held high 5 clk with 2 bytes queued -> exactly one pop, rxdata shows byte 2.
//  5 Frame 0x3C with stop bit 0 -> macro defined: not stored, ferr=1; undefined: stored.
//  6 rst pulsed 1 clk mid-frame (after 4 data bits) -> outputs at reset values; next frame
//    0x5A received intact; pop coinciding with push on full FIFO keeps count=16, no ovr.

Source files
------------

// File: rtl/zifi_uart_rx_if.sv
// zifi_uart_rx_if: line input and register front-end signals of the ZiFi UART receiver.
// The receiver takes the slave modport; whatever drives the line and reads bytes takes master.
interface zifi_uart_rx_if;
    logic       uart_rx;
    logic       data_read;
    logic [7:0] rxdata;
    logic       rxrecv;
    logic       rts;
    logic       ovr;
    logic       ferr;

    modport master (
        output uart_rx,
        output data_read,
        input  rxdata,
        input  rxrecv,
        input  rts,
        input  ovr,
        input  ferr
    );

    modport slave (
        input  uart_rx,
        input  data_read,
        output rxdata,
        output rxrecv,
        output rts,
        output ovr,
        output ferr
    );
endinterface

// File: rtl/zifi_uart_rx.sv
// zifi_uart_rx: 8N1 serial receiver with oversampled bit recovery, show-ahead receive
// FIFO and RTS flow control with hysteresis.
// Optional feature: define ZIFI_UART_RX_FRAME_CHECK_EN to discard bytes whose stop bit
// samples 0 and flag them on ferr; without it the stop bit is ignored and ferr is tied 0.
module zifi_uart_rx #(
    parameter int CLK_HZ  = 28000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4,
    parameter int RTS_HI  = 12,
    parameter int RTS_LO  = 4
) (
    input  logic          clk_bus,
    input  logic          rst,
    zifi_uart_rx_if.slave bus
);
    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW    = $clog2(DIV);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_HI   = CW'(RTS_HI);
    localparam logic [CW-1:0] C_LO   = CW'(RTS_LO);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic               sync1;
    logic               rxs;
    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               push_req;
    logic               start_ok;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               read_q;
    logic               pop;
    logic               push;
    logic               drop;
    logic [7:0]         head_d;
    logic [7:0]         rxdata_q;
    logic               rxrecv_q;
    logic               rts_q;
    logic               ovr_q;

`ifdef ZIFI_UART_RX_FRAME_CHECK_EN
    logic frame_err;
    logic hold_q, hold_d;
    logic ferr_q;

    // A low stop bit may be a break; no new start is accepted until the line has gone high.
    assign start_ok = ~hold_q;
    assign bus.ferr = ferr_q;
`else
    assign start_ok = 1'b1;
    assign bus.ferr = 1'b0;
`endif

    // Two-flop synchronizer on the asynchronous line, preset to the idle level.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= bus.uart_rx;
            rxs   <= sync1;
        end
    end

    // Receiver FSM state, bit timer, bit counter and shift register.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: half-bit start check, then centre sampling of 8 data bits and stop.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
`ifdef ZIFI_UART_RX_FRAME_CHECK_EN
        frame_err = 1'b0;
        hold_d    = hold_q & ~rxs;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rxs && start_ok) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
`ifdef ZIFI_UART_RX_FRAME_CHECK_EN
                    if (rxs) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                        hold_d    = 1'b1;
                    end
`else
                    push_req = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One pop per rising edge of data_read; a full FIFO still accepts a push when it also pops.
    assign pop  = bus.data_read & ~read_q & (count_q != '0);
    assign push = push_req & ((count_q != C_FULL) | pop);
    assign drop = push_req & ~push;

    // Next pointers/count and the head byte that becomes visible on rxdata next cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = 8'h00;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (count_d != '0) begin
            if (push && count_d == C_ONE) begin
                head_d = shift_q;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk_bus) begin
        if (push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    // FIFO pointers, registered outputs, RTS hysteresis and sticky overrun flag.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            read_q   <= 1'b0;
            rxdata_q <= 8'h00;
            rxrecv_q <= 1'b0;
            rts_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            read_q   <= bus.data_read;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rxdata_q <= head_d;
            rxrecv_q <= (count_d != '0);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (count_q >= C_HI) begin
                rts_q <= 1'b1;
            end else if (count_q <= C_LO) begin
                rts_q <= 1'b0;
            end
            if (pop) begin
                ovr_q <= 1'b0;
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

`ifdef ZIFI_UART_RX_FRAME_CHECK_EN
    // Break hold and sticky framing error; a valid pop clears the error.
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            hold_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            if (pop) begin
                ferr_q <= 1'b0;
            end
            if (frame_err) begin
                ferr_q <= 1'b1;
            end
        end
    end
`endif

    assign bus.rxdata = rxdata_q;
    assign bus.rxrecv = rxrecv_q;
    assign bus.rts    = rts_q;
    assign bus.ovr    = ovr_q;
endmodule

// File: tb/tb_zifi_uart_rx.sv
// tb_zifi_uart_rx: directed bench for zifi_uart_rx at 28 MHz / 115200 baud (243 clocks per bit).
// Expected values follow ZIFI_UART_RX_FRAME_CHECK_EN the same way the design does.
module tb_zifi_uart_rx;
    localparam int DIV = 243;

    logic clk_bus;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   lat;

    zifi_uart_rx_if bus ();

    zifi_uart_rx #(
        .CLK_HZ (28000000),
        .BAUD   (115200),
        .FIFO_AW(4),
        .RTS_HI (12),
        .RTS_LO (4)
    ) dut (
        .clk_bus(clk_bus),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame LSB first with the given stop bit level, then returns the line to idle.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        bus.uart_rx = 1'b0;
        repeat (DIV) @(posedge clk_bus);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = data[i];
            repeat (DIV) @(posedge clk_bus);
            #1;
        end
        bus.uart_rx = stop_bit;
        repeat (DIV) @(posedge clk_bus);
        #1;
        bus.uart_rx = 1'b1;
    endtask

    // Holds data_read high for the given number of clocks, then lets the outputs settle.
    task automatic popByte(input int hold);
        bus.data_read = 1'b1;
        repeat (hold) @(posedge clk_bus);
        #1;
        bus.data_read = 1'b0;
        repeat (2) @(posedge clk_bus);
        #1;
    endtask

    initial begin
        logic [7:0] pattern;
        logic [7:0] expect_byte;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.uart_rx   = 1'b1;
        bus.data_read = 1'b0;
        repeat (3) @(posedge clk_bus);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_rxrecv", bus.rxrecv, 1'b0);
        checkOutput("rst_rxdata", bus.rxdata, 8'h00);
        checkOutput("rst_rts", bus.rts, 1'b0);
        checkOutput("rst_ovr", bus.ovr, 1'b0);
        checkOutput("rst_ferr", bus.ferr, 1'b0);

        $display("[TB] single frame 0xA5 and latency");
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!bus.rxrecv && lat < 3000) begin
                    @(posedge clk_bus);
                    #1;
                    lat++;
                end
            end
        join
        $display("[TB] rxrecv rose %0d clocks after start edge", lat);
        checkOutput("t1_latency", (lat >= 2307 && lat <= 2313) ? 2310 : lat, 2310);
        checkOutput("t1_rxdata", bus.rxdata, 8'hA5);
        checkOutput("t1_rts", bus.rts, 1'b0);
        popByte(1);
        checkOutput("t1_empty", bus.rxrecv, 1'b0);

        $display("[TB] 50-clock glitch");
        bus.uart_rx = 1'b0;
        repeat (50) @(posedge clk_bus);
        #1;
        bus.uart_rx = 1'b1;
        repeat (300) @(posedge clk_bus);
        #1;
        checkOutput("t2_no_push", bus.rxrecv, 1'b0);
        applyStimulus(8'h81, 1'b1);
        checkOutput("t2_next_rxdata", bus.rxdata, 8'h81);
        popByte(1);
        checkOutput("t2_next_empty", bus.rxrecv, 1'b0);

        $display("[TB] 17 back-to-back frames, overflow, hysteresis");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(i), 1'b1);
            if (i == 10) checkOutput("t3_rts_at_11", bus.rts, 1'b0);
            if (i == 11) checkOutput("t3_rts_at_12", bus.rts, 1'b1);
        end
        checkOutput("t3_ovr", bus.ovr, 1'b1);
        checkOutput("t3_rxrecv", bus.rxrecv, 1'b1);
        checkOutput("t3_head", bus.rxdata, 8'h00);
        // The pop rising edge lands on the same clock as the push of the next frame.
        fork
            applyStimulus(8'h11, 1'b1);
            begin
                repeat (2310) @(posedge clk_bus);
                #1;
                bus.data_read = 1'b1;
                repeat (2) @(posedge clk_bus);
                #1;
                bus.data_read = 1'b0;
            end
        join
        checkOutput("t6_full_pushpop_ovr", bus.ovr, 1'b0);
        checkOutput("t6_full_pushpop_rts", bus.rts, 1'b1);
        checkOutput("t6_full_pushpop_head", bus.rxdata, 8'h01);
        for (int k = 1; k <= 16; k++) begin
            expect_byte = (k == 16) ? 8'h11 : 8'(k);
            checkOutput($sformatf("t3_read_%0d", k), bus.rxdata, expect_byte);
            popByte(2);
            if (k == 11) checkOutput("t3_rts_count5", bus.rts, 1'b1);
            if (k == 12) checkOutput("t3_rts_count4", bus.rts, 1'b0);
        end
        checkOutput("t3_drained", bus.rxrecv, 1'b0);

        $display("[TB] data_read held for 5 clocks");
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkOutput("t4_head_before", bus.rxdata, 8'h11);
        popByte(5);
        checkOutput("t4_head_after", bus.rxdata, 8'h22);
        checkOutput("t4_rxrecv", bus.rxrecv, 1'b1);

        $display("[TB] frame 0x3C with low stop bit");
        applyStimulus(8'h3C, 1'b0);
        repeat (DIV) @(posedge clk_bus);
        #1;
        checkOutput("t5_head", bus.rxdata, 8'h22);
`ifdef ZIFI_UART_RX_FRAME_CHECK_EN
        checkOutput("t5_ferr_set", bus.ferr, 1'b1);
        popByte(1);
        checkOutput("t5_not_stored", bus.rxrecv, 1'b0);
        checkOutput("t5_ferr_clear", bus.ferr, 1'b0);
`else
        checkOutput("t5_ferr_tied", bus.ferr, 1'b0);
        popByte(1);
        checkOutput("t5_stored", bus.rxdata, 8'h3C);
        checkOutput("t5_stored_valid", bus.rxrecv, 1'b1);
`endif

        $display("[TB] reset mid-frame");
        applyStimulus(8'h99, 1'b1);
        checkOutput("t6_pre_rxrecv", bus.rxrecv, 1'b1);
        pattern = 8'h5A;
        bus.uart_rx = 1'b0;
        repeat (DIV) @(posedge clk_bus);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus.uart_rx = pattern[i];
            repeat (DIV) @(posedge clk_bus);
            #1;
        end
        rst = 1'b1;
        @(posedge clk_bus);
        #1;
        rst = 1'b0;
        bus.uart_rx = 1'b1;
        checkOutput("t6_rst_rxrecv", bus.rxrecv, 1'b0);
        checkOutput("t6_rst_rxdata", bus.rxdata, 8'h00);
        checkOutput("t6_rst_rts", bus.rts, 1'b0);
        checkOutput("t6_rst_ovr", bus.ovr, 1'b0);
        checkOutput("t6_rst_ferr", bus.ferr, 1'b0);
        repeat (2 * DIV) @(posedge clk_bus);
        #1;
        checkOutput("t6_aborted_no_push", bus.rxrecv, 1'b0);
        applyStimulus(8'h5A, 1'b1);
        checkOutput("t6_next_rxdata", bus.rxdata, 8'h5A);
        checkOutput("t6_next_rxrecv", bus.rxrecv, 1'b1);
        popByte(1);
        checkOutput("t6_next_empty", bus.rxrecv, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
